match_controller: RTL and testbench

Round/match sequencer for the two-player fighter. Accepts attack requests from both players, applies damage to the opponent when the collision unit reports contact, and owns both health counters feeding the status bar. Runs the countdown → fight → KO → result flow and drives a freeze output that gates the physics engines outside the fight phase.

---
 rtl/match_controller.sv | 194 +++++++++++++++++++
 tb/tb_match_controller.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/match_controller.sv
// Round/match sequencer: edge-detected start/attacks, damage, health, COUNTDOWN->FIGHT->KO->RESULT; hits land one cycle after edge detection.
// MATCH_TIMER_EN enables the FIGHT round timer and timeout-to-KO; without it FIGHT ends only by KO.
module match_controller #(
  parameter int HEALTH_MAX   = 31,
  parameter int DAMAGE       = 4,
  parameter int COOLDOWN_CYC = 25_000_000,
  parameter int TICK_DIV     = 100_000_000,
  parameter int COUNTDOWN_S  = 3,
  parameter int ROUND_S      = 99,
  parameter int KO_HOLD_S    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       p1_attack,
  input  logic       p2_attack,
  input  logic       in_range,
  output logic [4:0] health_l,
  output logic [4:0] health_r,
  output logic [2:0] state,
  output logic       freeze,
  output logic [6:0] timer,
  output logic [1:0] winner,
  output logic       p1_hit,
  output logic       p2_hit
);
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_COUNTDOWN = 3'd1;
  localparam logic [2:0] S_FIGHT     = 3'd2;
  localparam logic [2:0] S_KO        = 3'd3;
  localparam logic [2:0] S_RESULT    = 3'd4;

  localparam int CD_W = $clog2(COOLDOWN_CYC + 1);
  localparam int TK_W = $clog2(TICK_DIV + 1);

`ifdef MATCH_TIMER_EN
  localparam logic TIMER_EN = 1'b1;
`else
  localparam logic TIMER_EN = 1'b0;
`endif
  localparam logic [6:0] FIGHT_LOAD = TIMER_EN ? 7'(ROUND_S) : 7'd0;

  logic [2:0]      state_q, state_d;
  logic [4:0]      health_l_q, health_l_d, health_r_q, health_r_d;
  logic [6:0]      timer_q, timer_d;
  logic [1:0]      winner_q, winner_d;
  logic            p1_hit_q, p1_hit_d, p2_hit_q, p2_hit_d;
  logic [CD_W-1:0] cd1_q, cd1_d, cd2_q, cd2_d;
  logic [TK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic            start_s_q, start_p_q, p1_s_q, p1_p_q, p2_s_q, p2_p_q;

  logic start_edge, p1_edge, p2_edge, tick, ko_now, timeout, fight_live, p1_acc, p2_acc;
  logic [1:0] ko_winner, to_winner;

  // Inputs pass one register stage; the edge is taken between that stage and its previous value.
  assign start_edge = start_s_q & ~start_p_q;
  assign p1_edge    = p1_s_q & ~p1_p_q;
  assign p2_edge    = p2_s_q & ~p2_p_q;
  assign tick       = (tick_cnt_q == TK_W'(TICK_DIV - 1));
  assign ko_now     = (health_l_q == 5'd0) || (health_r_q == 5'd0);
  assign timeout    = TIMER_EN && (state_q == S_FIGHT) && tick && (timer_q == 7'd1);
  assign fight_live = (state_q == S_FIGHT) && !ko_now && !timeout;
  assign p1_acc     = fight_live && p1_edge && (cd1_q == '0);
  assign p2_acc     = fight_live && p2_edge && (cd2_q == '0);
  assign ko_winner  = (health_l_q == 5'd0 && health_r_q == 5'd0) ? 2'b11 :
                      (health_l_q == 5'd0) ? 2'b10 : 2'b01;
  assign to_winner  = (health_l_q > health_r_q) ? 2'b01 :
                      (health_r_q > health_l_q) ? 2'b10 : 2'b11;

  function automatic logic [4:0] sub_dmg(input logic [4:0] h);
    logic [5:0] diff;
    diff = {1'b0, h} - 6'(DAMAGE);
    return diff[5] ? 5'd0 : diff[4:0];
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_RESULT: if (start_edge) state_d = S_COUNTDOWN;
      S_COUNTDOWN:      if (tick && timer_q == 7'd1) state_d = S_FIGHT;
      S_FIGHT:          if (ko_now || timeout) state_d = S_KO;
      S_KO:             if (tick && timer_q == 7'd1) state_d = S_RESULT;
      default:          state_d = S_IDLE;
    endcase
  end

  always_comb begin
    health_l_d = health_l_q;
    health_r_d = health_r_q;
    timer_d    = timer_q;
    winner_d   = winner_q;
    p1_hit_d   = 1'b0;
    p2_hit_d   = 1'b0;
    cd1_d      = (cd1_q == '0) ? '0 : cd1_q - CD_W'(1);
    cd2_d      = (cd2_q == '0) ? '0 : cd2_q - CD_W'(1);
    tick_cnt_d = (state_d != state_q || tick) ? '0 : tick_cnt_q + TK_W'(1);
    case (state_q)
      S_IDLE, S_RESULT: begin
        if (start_edge) begin
          health_l_d = 5'(HEALTH_MAX);
          health_r_d = 5'(HEALTH_MAX);
          timer_d    = 7'(COUNTDOWN_S);
          winner_d   = 2'b00;
          cd1_d      = '0;
          cd2_d      = '0;
        end
      end
      S_COUNTDOWN: begin
        if (tick) timer_d = (timer_q == 7'd1) ? FIGHT_LOAD : timer_q - 7'd1;
      end
      S_FIGHT: begin
        if (p1_acc) begin
          cd1_d = CD_W'(COOLDOWN_CYC);
          if (in_range) begin
            health_r_d = sub_dmg(health_r_q);
            p1_hit_d   = 1'b1;
          end
        end
        if (p2_acc) begin
          cd2_d = CD_W'(COOLDOWN_CYC);
          if (in_range) begin
            health_l_d = sub_dmg(health_l_q);
            p2_hit_d   = 1'b1;
          end
        end
        if (ko_now) begin
          winner_d = ko_winner;
          timer_d  = 7'(KO_HOLD_S);
        end else if (timeout) begin
          winner_d = to_winner;
          timer_d  = 7'(KO_HOLD_S);
        end else if (TIMER_EN && tick) begin
          timer_d = timer_q - 7'd1;
        end
      end
      S_KO: begin
        if (tick) timer_d = timer_q - 7'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      health_l_q <= 5'd0;
      health_r_q <= 5'd0;
      timer_q    <= 7'd0;
      winner_q   <= 2'b00;
      p1_hit_q   <= 1'b0;
      p2_hit_q   <= 1'b0;
      cd1_q      <= '0;
      cd2_q      <= '0;
      tick_cnt_q <= '0;
      start_s_q  <= 1'b0;
      start_p_q  <= 1'b0;
      p1_s_q     <= 1'b0;
      p1_p_q     <= 1'b0;
      p2_s_q     <= 1'b0;
      p2_p_q     <= 1'b0;
    end else begin
      health_l_q <= health_l_d;
      health_r_q <= health_r_d;
      timer_q    <= timer_d;
      winner_q   <= winner_d;
      p1_hit_q   <= p1_hit_d;
      p2_hit_q   <= p2_hit_d;
      cd1_q      <= cd1_d;
      cd2_q      <= cd2_d;
      tick_cnt_q <= tick_cnt_d;
      start_s_q  <= start;
      start_p_q  <= start_s_q;
      p1_s_q     <= p1_attack;
      p1_p_q     <= p1_s_q;
      p2_s_q     <= p2_attack;
      p2_p_q     <= p2_s_q;
    end
  end

  always_comb begin
    state    = state_q;
    freeze   = (state_q != S_FIGHT);
    health_l = health_l_q;
    health_r = health_r_q;
    timer    = timer_q;
    winner   = winner_q;
    p1_hit   = p1_hit_q;
    p2_hit   = p2_hit_q;
  end
endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with small tick/cooldown constants; honours MATCH_TIMER_EN.
module tb_match_controller;
`ifdef MATCH_TIMER_EN
  // A KO by damage from full health needs more than 5 ticks of fight, so the timed build uses a longer round.
  localparam int ROUND_TB = 15;
  localparam int FIGHT_T  = 15;
`else
  localparam int ROUND_TB = 5;
  localparam int FIGHT_T  = 0;
`endif

  logic       clk, reset, start, p1_attack, p2_attack, in_range;
  logic [4:0] health_l, health_r;
  logic [2:0] state;
  logic       freeze;
  logic [6:0] timer;
  logic [1:0] winner;
  logic       p1_hit, p2_hit;
  int         n_cmp = 0;
  int         n_err = 0;

  match_controller #(
    .HEALTH_MAX(31), .DAMAGE(4), .COOLDOWN_CYC(3), .TICK_DIV(4),
    .COUNTDOWN_S(3), .ROUND_S(ROUND_TB), .KO_HOLD_S(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .p1_attack(p1_attack),
    .p2_attack(p2_attack), .in_range(in_range), .health_l(health_l),
    .health_r(health_r), .state(state), .freeze(freeze), .timer(timer),
    .winner(winner), .p1_hit(p1_hit), .p2_hit(p2_hit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start edge, then COUNTDOWN for 3 ticks of 4 cycles; returns just after FIGHT entry.
  task automatic begin_match(input string tag);
    start = 1'b1; cyc(1); start = 1'b0; cyc(1);
    chk({tag, "_cd_state"}, int'(state), 1);
    chk({tag, "_cd_hl"}, int'(health_l), 31);
    chk({tag, "_cd_hr"}, int'(health_r), 31);
    chk({tag, "_cd_timer"}, int'(timer), 3);
    chk({tag, "_cd_winner"}, int'(winner), 0);
    chk({tag, "_cd_freeze"}, int'(freeze), 1);
    cyc(4);
    chk({tag, "_cd_timer_tick1"}, int'(timer), 2);
    cyc(7);
    chk({tag, "_cd_last_cycle"}, int'(state), 1);
    cyc(1);
    chk({tag, "_fight_state"}, int'(state), 2);
    chk({tag, "_fight_freeze"}, int'(freeze), 0);
    chk({tag, "_fight_timer"}, int'(timer), FIGHT_T);
  endtask

  task automatic hit_pair(input logic a1, input logic a2);
    p1_attack = a1; p2_attack = a2; cyc(1);
    p1_attack = 1'b0; p2_attack = 1'b0; cyc(3);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; p1_attack = 1'b0; p2_attack = 1'b0; in_range = 1'b0;
    cyc(3);
    chk("rst_state", int'(state), 0);
    chk("rst_hl", int'(health_l), 0);
    chk("rst_hr", int'(health_r), 0);
    chk("rst_timer", int'(timer), 0);
    chk("rst_winner", int'(winner), 0);
    chk("rst_freeze", int'(freeze), 1);
    chk("rst_hits", int'({p1_hit, p2_hit}), 0);
    reset = 1'b1; cyc(2);
    chk("idle_hold", int'(state), 0);

    // Match 1: one hit, then asynchronous reset mid-FIGHT.
    begin_match("m1");
    in_range = 1'b1;
    hit_pair(1'b1, 1'b0);
    chk("m1_hit_hr", int'(health_r), 27);
    #2 reset = 1'b0; #1;
    chk("arst_state", int'(state), 0);
    chk("arst_hl", int'(health_l), 0);
    chk("arst_hr", int'(health_r), 0);
    chk("arst_freeze", int'(freeze), 1);
    chk("arst_timer", int'(timer), 0);
    cyc(2); reset = 1'b1; cyc(1);

    // Match 2: hit with cooldown, miss, cooldown boundary, simultaneous KO.
    begin_match("m2");
    p1_attack = 1'b1; cyc(1);
    p1_attack = 1'b0; cyc(1);
    chk("hit1_hr", int'(health_r), 27);
    chk("hit1_pulse", int'(p1_hit), 1);
    chk("hit1_hl", int'(health_l), 31);
    p1_attack = 1'b1; cyc(1);
    p1_attack = 1'b0;
    chk("hit1_pulse_end", int'(p1_hit), 0);
    cyc(1);
    chk("cool_reject_hr", int'(health_r), 27);
    chk("cool_reject_pulse", int'(p1_hit), 0);
    cyc(1);
    p1_attack = 1'b1; cyc(1);
    p1_attack = 1'b0; cyc(1);
    chk("hit3_hr", int'(health_r), 23);
    chk("hit3_pulse", int'(p1_hit), 1);

    in_range = 1'b0;
    p2_attack = 1'b1; cyc(1);
    p2_attack = 1'b0; cyc(1);
    chk("miss_hl", int'(health_l), 31);
    chk("miss_pulse", int'(p2_hit), 0);
    in_range = 1'b1; cyc(1);
    p2_attack = 1'b1; cyc(1);
    p2_attack = 1'b0; cyc(1);
    chk("cd1_reject_hl", int'(health_l), 31);
    chk("cd1_reject_pulse", int'(p2_hit), 0);
    p2_attack = 1'b1; cyc(1);
    p2_attack = 1'b0; cyc(1);
    chk("cd0_accept_hl", int'(health_l), 27);
    chk("cd0_accept_pulse", int'(p2_hit), 1);

    cyc(3);
    repeat (5) hit_pair(1'b1, 1'b1);
    hit_pair(1'b0, 1'b1);
    chk("pre_ko_hl", int'(health_l), 3);
    chk("pre_ko_hr", int'(health_r), 3);
    p1_attack = 1'b1; p2_attack = 1'b1; cyc(1);
    p1_attack = 1'b0; p2_attack = 1'b0; cyc(1);
    chk("ko_hl", int'(health_l), 0);
    chk("ko_hr", int'(health_r), 0);
    chk("ko_hits", int'({p1_hit, p2_hit}), 3);
    chk("ko_state_lag", int'(state), 2);
    cyc(1);
    chk("ko_state", int'(state), 3);
    chk("ko_winner", int'(winner), 3);
    chk("ko_freeze", int'(freeze), 1);
    chk("ko_timer", int'(timer), 2);
    cyc(7);
    chk("ko_hold", int'(state), 3);
    cyc(1);
    chk("res_state", int'(state), 4);
    chk("res_winner", int'(winner), 3);
    chk("res_timer", int'(timer), 0);
    cyc(3);
    chk("res_hold_winner", int'(winner), 3);

    // Match 3: restart from RESULT, ignored start in FIGHT, timeout behaviour.
    begin_match("m3");
    hit_pair(1'b0, 1'b1);
    chk("to_hl", int'(health_l), 27);
    chk("to_hr", int'(health_r), 31);
    start = 1'b1; cyc(1);
    start = 1'b0; cyc(1);
    chk("ign_start_state", int'(state), 2);
    chk("ign_start_hl", int'(health_l), 27);
    cyc(4 * ROUND_TB - 7);
    chk("to_before", int'(state), 2);
    cyc(1);
`ifdef MATCH_TIMER_EN
    chk("to_state", int'(state), 3);
    chk("to_winner", int'(winner), 2);
    chk("to_timer", int'(timer), 2);
`else
    chk("to_state", int'(state), 2);
    chk("to_timer", int'(timer), 0);
    chk("to_winner", int'(winner), 0);
    chk("to_freeze", int'(freeze), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
